sha3_padder: RTL and testbench
==============================

Name: sha3_padder

Overview:
- Producer side of the 576-bit rate-block interface consumed by the SHA3-512 Keccak permutation core.
- Accepts the message as 64-bit words and assembles 9 words into a 576-bit block.
- Applies SHA-3 domain padding (0x06 … 0x80) to the final block.
- Presents each block with a ready/ack handshake that matches the permutation's `iReady`/`oAck` pair.

Parameters:
- None. Rate is fixed at 576 bits (9 × 64-bit words) for SHA3-512.

Ports:
- `iClk` in 1: clock; all logic on rising edge.
- `iRst_n` in 1: reset; synchronous, active-low.
- `iData` in 64: message word; first message byte in [63:56].
- `iValid` in 1: `iData`/`iLast`/`iByteNum` valid this cycle.
- `iLast` in 1: this word is the final (partial) word of the message.
- `iByteNum` in 3: number of valid bytes in the last word (0..7); used only when `iLast`=1.
- `oBusy` out 1: word not accepted this cycle. A word is accepted iff `iValid & ~oBusy`.
- `oData` out 576: assembled block; word 0 in [575:512], word 8 in [63:0].
- `oReady` out 1: `oData` holds a complete block (drives the permutation's `iReady`).
- `iAck` in 1: consumer took the block (driven from the permutation's `oAck`).
- `oLastBlock` out 1: the block in `oData` is the padded final block of the message; valid while `oReady`=1.

Behaviour:
- Reset (`iRst_n`=0 at a clock edge):
  - Buffer zeroed; word counter `cnt`=0; FSM to FILL.
  - `oReady`=0, `oBusy`=0, `oLastBlock`=0.
  - Any partial block is discarded, including a reset while in PAD or FULL.
- FSM states:
  - FILL: `oBusy`=0, `oReady`=0.
    - Accepted non-last word → written to slot `cnt`, `cnt`+1.
    - If `cnt` was 8 → go to FULL, `oLastBlock`<=0.
    - Accepted last word → go to PAD.
  - PAD: one cycle, `oBusy`=1, `oReady`=0.
    - Slot k (the last-word slot) = valid bytes of `iData`, then 0x06 at byte index `iByteNum`, then zeros. Bytes beyond `iByteNum` are masked to 0 regardless of input.
    - Slots k+1..8 are zero.
    - `oData[7:0]` OR= 0x80, so 0x86 when the 0x06 byte lands at byte 71.
    - Go to FULL with `oLastBlock`<=1.
    - The padding is latched from the last word at accept time; PAD only completes the zero-fill/OR.
  - FULL: `oReady`=1, `oBusy`=1, `oData` stable.
    - `iAck`=1 → next cycle: buffer cleared, `cnt`=0, FILL, `oReady`=0, `oLastBlock`=0.
    - `iAck`=0 → hold indefinitely.
- Latency:
  - Non-final block: `oReady` rises the cycle after the 9th word is accepted.
  - Final block: `oReady` rises 2 cycles after the last word is accepted.
- Last word and padding rules:
  - The last word carries at most 7 bytes, so padding always fits in the current block. No extra block is ever generated.
  - A message whose length is a multiple of 8 bytes ends with `iLast`=1, `iByteNum`=0; the `iData` content is ignored.
  - If that word falls in slot 0, it produces a full padding-only block.
- `iAck` while `oReady`=0 is ignored.
- `iValid` while `oBusy`=1 is not accepted; the source must hold the word.
- `iByteNum` is ignored when `iLast`=0.
- Back-to-back messages: the next message's words are accepted in the cycle after the final-block ack.
- `cnt` is 4 bits, range 0..8; it never wraps past 8.

Test Plan:
- Empty message: `iValid`=1, `iLast`=1, `iByteNum`=0 → 2 cycles later `oReady`=1, `oLastBlock`=1, `oData[575:568]`=0x06, `oData[7:0]`=0x80, all other bits 0; `iAck` → `oReady`=0 next cycle.
- "abc": `iData`=0x616263FFFFFFFFFF, `iLast`=1, `iByteNum`=3 → `oData[575:512]`=0x6162630600000000, `oData[7:0]`=0x80, rest 0 (junk bytes masked).
- 71 bytes: 8 full words 0x1111111111111111, then last word 0x22…22 with `iByteNum`=7 → `oData[63:0]`=0x2222222222222286, `oLastBlock`=1.
- 72 bytes: 9 full words then `iLast`/`iByteNum`=0 → first block `oLastBlock`=0 with data intact; after `iAck`, second block `oData[575:568]`=0x06, `oData[7:0]`=0x80, `oLastBlock`=1.
- Back-pressure: in FULL hold `iAck`=0 for 5 cycles with `iValid`=1 → `oBusy`=1, `oData`/`oReady` unchanged, no word consumed. Raise `iAck` → first pending word is accepted the cycle after FILL is re-entered.
- Reset mid-block: accept 4 words, pull `iRst_n`=0 for one cycle → `cnt`=0, `oReady`=0, buffer zero. A subsequent empty message yields exactly the empty-message block.

Source files
------------

// File: rtl/sha3_padder.sv
// SHA3-512 rate-block producer: packs 64-bit message words into 576-bit blocks,
// applies the 0x06...0x80 domain padding to the final block and hands blocks over with ready/ack.
module sha3_padder (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic [63:0]  iData,
    input  logic         iValid,
    input  logic         iLast,
    input  logic [2:0]   iByteNum,
    output logic         oBusy,
    output logic [575:0] oData,
    output logic         oReady,
    input  logic         iAck,
    output logic         oLastBlock
);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [63:0] slot [9];
    logic        last_block;
    logic [63:0] pad_word;
    logic        accept;

    assign accept     = iValid && (state == ST_FILL);
    assign oBusy      = (state != ST_FILL);
    assign oReady     = (state == ST_FULL);
    assign oLastBlock = last_block;

    // Last word: keep the valid leading bytes, drop the 0x06 marker right after them, zero the rest.
    always_comb begin
        pad_word = '0;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) < iByteNum)
                pad_word[63-8*j -: 8] = iData[63-8*j -: 8];
            else if (3'(j) == iByteNum)
                pad_word[63-8*j -: 8] = 8'h06;
        end
    end

    always_comb begin
        oData = '0;
        for (int i = 0; i < 9; i++)
            oData[575-64*i -: 64] = slot[i];
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state      <= ST_FILL;
            cnt        <= '0;
            last_block <= 1'b0;
            for (int i = 0; i < 9; i++)
                slot[i] <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (iLast) begin
                            slot[cnt] <= pad_word;
                            state     <= ST_PAD;
                        end else begin
                            slot[cnt] <= iData;
                            if (cnt == 4'd8) begin
                                state      <= ST_FULL;
                                last_block <= 1'b0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                end
                // cnt still points at the last-word slot, so everything after it is zero-filled.
                ST_PAD: begin
                    for (int i = 0; i < 9; i++)
                        if (4'(i) > cnt)
                            slot[i] <= '0;
                    slot[8][7:0] <= ((cnt == 4'd8) ? slot[8][7:0] : 8'h00) | 8'h80;
                    state        <= ST_FULL;
                    last_block   <= 1'b1;
                end
                ST_FULL: begin
                    if (iAck) begin
                        state      <= ST_FILL;
                        cnt        <= '0;
                        last_block <= 1'b0;
                        for (int i = 0; i < 9; i++)
                            slot[i] <= '0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_padder.sv
// Testbench for sha3_padder: directed corner messages plus random messages checked
// against a byte-level SHA-3 padding model.
module tb_sha3_padder;

    typedef logic [7:0] bq_t [$];

    logic         iClk = 1'b0;
    logic         iRst_n;
    logic [63:0]  iData;
    logic         iValid;
    logic         iLast;
    logic [2:0]   iByteNum;
    logic         oBusy;
    logic [575:0] oData;
    logic         oReady;
    logic         iAck;
    logic         oLastBlock;

    int errors = 0;
    int checks = 0;

    logic [575:0] exp_blk [$];
    logic         exp_last [$];

    sha3_padder dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iData      (iData),
        .iValid     (iValid),
        .iLast      (iLast),
        .iByteNum   (iByteNum),
        .oBusy      (oBusy),
        .oData      (oData),
        .oReady     (oReady),
        .iAck       (iAck),
        .oLastBlock (oLastBlock)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [575:0] got, input logic [575:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: append 0x06, zero-fill to a multiple of 72 bytes, OR 0x80 into the final byte.
    task automatic modelPush(input bq_t msg, output int nblk);
        bq_t p;
        int padded;
        logic [575:0] blk;
        p = msg;
        padded = ((msg.size() + 1 + 71) / 72) * 72;
        p.push_back(8'h06);
        while (p.size() < padded)
            p.push_back(8'h00);
        p[padded-1] = p[padded-1] | 8'h80;
        nblk = padded / 72;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 72; i++)
                blk[575-8*i -: 8] = p[72*b+i];
            exp_blk.push_back(blk);
            exp_last.push_back(b == nblk - 1);
        end
    endtask

    task automatic driveWord(input logic [63:0] d, input logic last, input logic [2:0] bn);
        int waits = 0;
        @(negedge iClk);
        iValid   = 1'b1;
        iData    = d;
        iLast    = last;
        iByteNum = bn;
        while (oBusy && waits < 400) begin
            @(negedge iClk);
            waits++;
        end
        if (oBusy)
            checkOutput("accept_timeout", 1'b1, 1'b0);
        @(posedge iClk);
    endtask

    task automatic applyStimulus(input bq_t msg);
        int L;
        logic [63:0] w;
        L = msg.size();
        for (int k = 0; k < L / 8; k++) begin
            if ($urandom_range(3) == 0) begin
                @(negedge iClk);
                iValid = 1'b0;
            end
            for (int j = 0; j < 8; j++)
                w[63-8*j -: 8] = msg[8*k+j];
            driveWord(w, 1'b0, 3'($urandom));
        end
        w = {$urandom, $urandom};
        for (int j = 0; j < L % 8; j++)
            w[63-8*j -: 8] = msg[8*(L/8)+j];
        driveWord(w, 1'b1, 3'(L % 8));
        @(negedge iClk);
        iValid = 1'b0;
        iLast  = 1'b0;
    endtask

    task automatic monitorBlocks(input int n);
        int done = 0;
        int cyc = 0;
        bit seen = 0;
        while (done < n && cyc < 5000) begin
            @(negedge iClk);
            cyc++;
            iAck = 1'b0;
            if (oReady && !seen) begin
                if (exp_blk.size() == 0) begin
                    checkOutput("extra_block", 1'b1, 1'b0);
                end else begin
                    checkOutput("block_data", oData, exp_blk.pop_front());
                    checkOutput("block_last", oLastBlock, exp_last.pop_front());
                end
                seen = 1;
            end
            if (oReady && seen && $urandom_range(2) == 0) begin
                iAck = 1'b1;
                seen = 0;
                done++;
            end
        end
        if (done < n)
            checkOutput("monitor_timeout", 576'(done), 576'(n));
        @(negedge iClk);
        iAck = 1'b0;
    endtask

    task automatic runMessage(input bq_t msg);
        int n;
        modelPush(msg, n);
        fork
            applyStimulus(msg);
            monitorBlocks(n);
        join
    endtask

    initial begin
        bq_t m;
        int n;
        logic [63:0] w;

        iRst_n = 1'b0; iValid = 1'b0; iData = '0; iLast = 1'b0; iByteNum = '0; iAck = 1'b0;
        repeat (2) @(negedge iClk);
        checkOutput("rst_ready", oReady, 1'b0);
        checkOutput("rst_busy", oBusy, 1'b0);
        checkOutput("rst_last", oLastBlock, 1'b0);
        checkOutput("rst_data", oData, '0);
        iRst_n = 1'b1;

        // Empty message with exact latency
        driveWord(64'hDEAD_BEEF_0123_4567, 1'b1, 3'd0);
        @(negedge iClk);
        iValid = 1'b0;
        checkOutput("empty_pad_ready", oReady, 1'b0);
        checkOutput("empty_pad_busy", oBusy, 1'b1);
        @(negedge iClk);
        checkOutput("empty_ready", oReady, 1'b1);
        checkOutput("empty_last", oLastBlock, 1'b1);
        checkOutput("empty_data", oData, {8'h06, 560'd0, 8'h80});
        iAck = 1'b1;
        @(negedge iClk);
        iAck = 1'b0;
        checkOutput("empty_ack_ready", oReady, 1'b0);
        checkOutput("empty_ack_busy", oBusy, 1'b0);
        checkOutput("empty_ack_data", oData, '0);

        m = {8'h61, 8'h62, 8'h63};
        runMessage(m);

        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'h11);
        for (int i = 0; i < 7; i++) m.push_back(8'h22);
        runMessage(m);

        m = {};
        for (int i = 0; i < 72; i++) m.push_back(8'(i + 1));
        runMessage(m);

        // Back-pressure: pending last word held while the full block is not acked
        m = {};
        for (int i = 0; i < 74; i++) m.push_back(8'($urandom));
        modelPush(m, n);
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 8; j++) w[63-8*j -: 8] = m[8*k+j];
            driveWord(w, 1'b0, 3'd5);
        end
        w = {m[72], m[73], 48'hFFFF_FFFF_FFFF};
        @(negedge iClk);
        iValid = 1'b1; iData = w; iLast = 1'b1; iByteNum = 3'd2;
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_busy", oBusy, 1'b1);
            checkOutput("bp_ready", oReady, 1'b1);
            checkOutput("bp_data", oData, exp_blk[0]);
            checkOutput("bp_last", oLastBlock, exp_last[0]);
            @(negedge iClk);
        end
        iAck = 1'b1;
        @(negedge iClk);
        iAck = 1'b0;
        checkOutput("bp_refill_busy", oBusy, 1'b0);
        checkOutput("bp_refill_ready", oReady, 1'b0);
        @(negedge iClk);
        iValid = 1'b0;
        checkOutput("bp_accepted_busy", oBusy, 1'b1);
        checkOutput("bp_accepted_ready", oReady, 1'b0);
        @(negedge iClk);
        checkOutput("bp_final_ready", oReady, 1'b1);
        checkOutput("bp_final_data", oData, exp_blk[1]);
        checkOutput("bp_final_last", oLastBlock, 1'b1);
        void'(exp_blk.pop_front()); void'(exp_blk.pop_front());
        void'(exp_last.pop_front()); void'(exp_last.pop_front());
        iAck = 1'b1;
        @(negedge iClk);
        iAck = 1'b0;

        // Reset in the middle of a block discards it
        for (int k = 0; k < 4; k++)
            driveWord({$urandom, $urandom}, 1'b0, 3'd0);
        @(negedge iClk);
        iValid = 1'b0;
        iRst_n = 1'b0;
        @(negedge iClk);
        iRst_n = 1'b1;
        checkOutput("midrst_ready", oReady, 1'b0);
        checkOutput("midrst_busy", oBusy, 1'b0);
        checkOutput("midrst_data", oData, '0);
        m = {};
        runMessage(m);

        for (int t = 0; t < 25; t++) begin
            m = {};
            n = $urandom_range(200);
            for (int i = 0; i < n; i++) m.push_back(8'($urandom));
            runMessage(m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
